// File: rtl/snake_grid_render.sv
// snake_grid_render: walks the active video area as a grid of cells.
// For each cell it fetches a 2-bit code from the board BSRAM and drives RGB.
// DE/HS/VS leave aligned with the pixel data, three cycles after entry.
// Build option: define SNAKE_GRID_LINE_EN to draw a 404040 grid line on the
// first column and the first line of every cell. Without it, cells are solid.
module snake_grid_render #(
  parameter int CELL_W = 16,
  parameter int CELL_H = 16,
  parameter int GRID_W = 40,
  parameter int GRID_H = 30,
  parameter int ADDR_W = 11
) (
  input  logic              I_pxl_clk,
  input  logic              I_rst_n,
  input  logic              I_de,
  input  logic              I_hs,
  input  logic              I_vs,
  output logic              O_rd_en,
  output logic [ADDR_W-1:0] O_rd_addr,
  input  logic [1:0]        I_rd_data,
  output logic [7:0]        O_r,
  output logic [7:0]        O_g,
  output logic [7:0]        O_b,
  output logic              O_de,
  output logic              O_hs,
  output logic              O_vs
);

  localparam int CS_W = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam int RS_W = (CELL_H > 1) ? $clog2(CELL_H) : 1;
  localparam int CI_W = $clog2(GRID_W + 1);
  localparam int RI_W = $clog2(GRID_H + 1);

`ifdef SNAKE_GRID_LINE_EN
  localparam bit LINE_EN = 1'b1;
`else
  localparam bit LINE_EN = 1'b0;
`endif

  // Maps the stage-2 sideband and the BSRAM code to the output colour.
  function automatic logic [23:0] pixel_color(input logic de, input logic flag,
                                              input logic in_grid, input logic line,
                                              input logic [1:0] code);
    logic [23:0] c;
    if (!de || !flag)        c = 24'h000000;
    else if (!in_grid)       c = 24'h202020;
    else if (LINE_EN && line) c = 24'h404040;
    else begin
      case (code)
        2'd1:    c = 24'h00C000;
        2'd2:    c = 24'h00FF80;
        2'd3:    c = 24'hFF0000;
        default: c = 24'h000000;
      endcase
    end
    return c;
  endfunction

  logic [CS_W-1:0]   r_col_sub;
  logic [CI_W-1:0]   r_col_idx;
  logic [RS_W-1:0]   r_row_sub;
  logic [RI_W-1:0]   r_row_idx;
  logic [ADDR_W-1:0] r_row_base;
  logic              r_flag;

  logic              r_rd_en_p1, r_in_grid_p1, r_line_p1, r_flag_p1;
  logic              r_de_p1, r_hs_p1, r_vs_p1;
  logic [ADDR_W-1:0] r_rd_addr_p1;
  logic              r_in_grid_p2, r_line_p2, r_flag_p2;
  logic              r_de_p2, r_hs_p2, r_vs_p2;
  logic [23:0]       r_rgb_p3;
  logic              r_de_p3, r_hs_p3, r_vs_p3;

  logic              w_de_fall;
  logic              w_in_grid;
  logic              w_line;
  logic [ADDR_W-1:0] w_addr;
  logic [23:0]       w_rgb;

  // r_de_p1 is the previous-cycle I_de, so it also serves as the edge detector.
  assign w_de_fall = r_de_p1 & ~I_de;
  assign w_in_grid = r_flag & I_de & (r_col_idx < CI_W'(GRID_W)) & (r_row_idx < RI_W'(GRID_H));
  assign w_line    = (r_col_sub == '0) | (r_row_sub == '0);
  assign w_addr    = r_row_base + ADDR_W'(r_col_idx);
  assign w_rgb     = pixel_color(r_de_p2, r_flag_p2, r_in_grid_p2, r_line_p2, I_rd_data);

  // Column walk: pixel within cell and cell index, cleared during blanking.
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_col_sub <= '0;
      r_col_idx <= '0;
    end else if (!I_de) begin
      r_col_sub <= '0;
      r_col_idx <= '0;
    end else if (r_col_sub == CS_W'(CELL_W - 1)) begin
      r_col_sub <= '0;
      if (r_col_idx < CI_W'(GRID_W)) r_col_idx <= r_col_idx + 1'b1;
    end else begin
      r_col_sub <= r_col_sub + 1'b1;
    end
  end

  // Row walk: advances on each DE falling edge; row_base is accumulated instead of a multiply.
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_row_sub  <= '0;
      r_row_idx  <= '0;
      r_row_base <= '0;
    end else if (I_vs) begin
      r_row_sub  <= '0;
      r_row_idx  <= '0;
      r_row_base <= '0;
    end else if (w_de_fall) begin
      if (r_row_sub == RS_W'(CELL_H - 1)) begin
        r_row_sub <= '0;
        if (r_row_idx < RI_W'(GRID_H)) begin
          r_row_idx  <= r_row_idx + 1'b1;
          r_row_base <= r_row_base + ADDR_W'(GRID_W);
        end
      end else begin
        r_row_sub <= r_row_sub + 1'b1;
      end
    end
  end

  // Frame sync flag: colour output is suppressed until the first vsync is seen.
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n)  r_flag <= 1'b0;
    else if (I_vs) r_flag <= 1'b1;
  end

  // Stage 1: board read request plus sideband.
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_rd_en_p1   <= 1'b0;
      r_rd_addr_p1 <= '0;
      r_in_grid_p1 <= 1'b0;
      r_line_p1    <= 1'b0;
      r_flag_p1    <= 1'b0;
      r_de_p1      <= 1'b0;
      r_hs_p1      <= 1'b0;
      r_vs_p1      <= 1'b0;
    end else begin
      r_rd_en_p1   <= w_in_grid;
      if (w_in_grid) r_rd_addr_p1 <= w_addr;
      r_in_grid_p1 <= w_in_grid;
      r_line_p1    <= w_line;
      r_flag_p1    <= r_flag;
      r_de_p1      <= I_de;
      r_hs_p1      <= I_hs;
      r_vs_p1      <= I_vs;
    end
  end

  // Stage 2: sideband waits while the BSRAM produces the cell code.
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_in_grid_p2 <= 1'b0;
      r_line_p2    <= 1'b0;
      r_flag_p2    <= 1'b0;
      r_de_p2      <= 1'b0;
      r_hs_p2      <= 1'b0;
      r_vs_p2      <= 1'b0;
    end else begin
      r_in_grid_p2 <= r_in_grid_p1;
      r_line_p2    <= r_line_p1;
      r_flag_p2    <= r_flag_p1;
      r_de_p2      <= r_de_p1;
      r_hs_p2      <= r_hs_p1;
      r_vs_p2      <= r_vs_p1;
    end
  end

  // Stage 3: registered colour and aligned syncs.
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_rgb_p3 <= '0;
      r_de_p3  <= 1'b0;
      r_hs_p3  <= 1'b0;
      r_vs_p3  <= 1'b0;
    end else begin
      r_rgb_p3 <= w_rgb;
      r_de_p3  <= r_de_p2;
      r_hs_p3  <= r_hs_p2;
      r_vs_p3  <= r_vs_p2;
    end
  end

  assign O_rd_en   = r_rd_en_p1;
  assign O_rd_addr = r_rd_addr_p1;
  assign O_r       = r_rgb_p3[23:16];
  assign O_g       = r_rgb_p3[15:8];
  assign O_b       = r_rgb_p3[7:0];
  assign O_de      = r_de_p3;
  assign O_hs      = r_hs_p3;
  assign O_vs      = r_vs_p3;

endmodule

// File: tb/tb_snake_grid_render.sv
// Bench for snake_grid_render with a small grid. The expected colour is derived
// from the screen position (line count since vsync, pixel count in the DE run)
// and from a board array that is also served as a 1-cycle-latency BSRAM.
module tb_snake_grid_render;
  localparam int CELL_W = 4;
  localparam int CELL_H = 2;
  localparam int GRID_W = 5;
  localparam int GRID_H = 3;
  localparam int ADDR_W = 4;
  localparam int MEM_N  = 1 << ADDR_W;

`ifdef SNAKE_GRID_LINE_EN
  localparam bit LINE_EN = 1'b1;
`else
  localparam bit LINE_EN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic de = 1'b0, hs = 1'b0, vs = 1'b0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        rd_data = 2'd0;
  logic [7:0]        r, g, b;
  logic              ode, ohs, ovs;
  logic [1:0]        board [0:MEM_N-1];

  int nvec = 0, nfail = 0;

  int                m_pix, m_line;
  bit                m_flag, m_prev_de;
  logic [ADDR_W-1:0] m_addr;
  logic [23:0]       h_col [3];
  logic              h_de [3], h_hs [3], h_vs [3];

  snake_grid_render #(.CELL_W(CELL_W), .CELL_H(CELL_H), .GRID_W(GRID_W),
                      .GRID_H(GRID_H), .ADDR_W(ADDR_W)) dut (
    .I_pxl_clk(clk), .I_rst_n(rst_n), .I_de(de), .I_hs(hs), .I_vs(vs),
    .O_rd_en(rd_en), .O_rd_addr(rd_addr), .I_rd_data(rd_data),
    .O_r(r), .O_g(g), .O_b(b), .O_de(ode), .O_hs(ohs), .O_vs(ovs)
  );

  always #5 clk = ~clk;

  // Board BSRAM: one cycle read latency.
  always @(posedge clk) rd_data <= board[rd_addr];

  function automatic logic [23:0] code_rgb(input logic [1:0] c);
    case (c)
      2'd0:    return 24'h000000;
      2'd1:    return 24'h00C000;
      2'd2:    return 24'h00FF80;
      default: return 24'hFF0000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_pix = 0; m_line = 0; m_flag = 0; m_prev_de = 0; m_addr = '0;
    for (int i = 0; i < 3; i++) begin
      h_col[i] = '0; h_de[i] = 0; h_hs[i] = 0; h_vs[i] = 0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rgb"}, {8'd0, r, g, b}, 32'd0);
    chk({tag, "_sync"}, {29'd0, ode, ohs, ovs}, 32'd0);
    chk({tag, "_rd"}, {27'd0, rd_en, rd_addr}, 32'd0);
  endtask

  task automatic step(input logic s_de, input logic s_hs, input logic s_vs);
    int cx, cy;
    bit ing;
    logic [23:0] col;
    logic [ADDR_W-1:0] a;
    de = s_de; hs = s_hs; vs = s_vs;
    cx  = m_pix / CELL_W;
    cy  = m_line / CELL_H;
    ing = m_flag && s_de && (cx < GRID_W) && (cy < GRID_H);
    a   = ing ? ADDR_W'(cy * GRID_W + cx) : m_addr;
    if (!s_de || !m_flag) col = 24'h000000;
    else if (!ing)        col = 24'h202020;
    else if (LINE_EN && ((m_pix % CELL_W) == 0 || (m_line % CELL_H) == 0)) col = 24'h404040;
    else                  col = code_rgb(board[cy * GRID_W + cx]);
    if (s_vs) m_line = 0;
    else if (m_prev_de && !s_de) m_line++;
    m_pix = s_de ? m_pix + 1 : 0;
    if (s_vs) m_flag = 1;
    m_prev_de = s_de;
    m_addr = a;
    for (int i = 2; i > 0; i--) begin
      h_col[i] = h_col[i-1]; h_de[i] = h_de[i-1]; h_hs[i] = h_hs[i-1]; h_vs[i] = h_vs[i-1];
    end
    h_col[0] = col; h_de[0] = s_de; h_hs[0] = s_hs; h_vs[0] = s_vs;
    @(posedge clk); #1;
    chk("rd_en", {31'd0, rd_en}, {31'd0, ing});
    chk("rd_addr", {28'd0, rd_addr}, {28'd0, a});
    chk("rgb", {8'd0, r, g, b}, {8'd0, h_col[2]});
    chk("sync", {29'd0, ode, ohs, ovs}, {29'd0, h_de[2], h_hs[2], h_vs[2]});
  endtask

  task automatic line(input int de_len, input int hbl);
    for (int p = 0; p < de_len; p++) step(1'b1, 1'b0, 1'b0);
    for (int p = 0; p < hbl; p++) step(1'b0, p == 1, 1'b0);
  endtask

  task automatic frame(input int nlines, input int de_len, input int hbl, input bit vs_at_fall);
    step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b1, 1'b1); step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    for (int l = 0; l < nlines; l++) begin
      if (vs_at_fall && l == nlines - 1) line(de_len, 0);
      else line(de_len, hbl);
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_N; i++) board[i] = 2'd0;
    board[0] = 2'd3;
    board[GRID_W + 1] = 2'd2;
    model_reset();

    // Reset held with DE toggling: everything stays zero.
    for (int i = 0; i < 6; i++) begin
      de = i[0]; hs = i[1]; vs = 1'b0;
      @(posedge clk); #1;
      chk_zero("reset");
    end
    de = 0; hs = 0;
    rst_n = 1'b1;

    // No vsync yet: syncs propagate, reads and colour stay off.
    for (int l = 0; l < 3; l++) line(9, 4);
    step(1'b0, 1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);

    // Directed frame: food at cell 0, head at cell (1,1), border beyond the grid.
    frame(GRID_H * CELL_H + 2, GRID_W * CELL_W + 6, 6, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Reset in the middle of a line, then recovery only after the next vsync.
    frame(2, GRID_W * CELL_W + 4, 5, 1'b0);
    for (int p = 0; p < 7; p++) step(1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk_zero("rst_hold");
    end
    rst_n = 1'b1;
    line(9, 4);
    line(GRID_W * CELL_W + 6, 4);
    frame(GRID_H * CELL_H + 1, GRID_W * CELL_W + 6, 6, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Randomised boards and line geometry, including short DE pulses and vsync at a DE fall.
    for (int f = 0; f < 14; f++) begin
      for (int i = 0; i < MEM_N; i++) board[i] = 2'($urandom_range(0, 3));
      if (f == 3) for (int i = 0; i < MEM_N; i++) board[i] = 2'd1;
      frame($urandom_range(3, GRID_H * CELL_H + 3),
            (f % 3 == 0) ? $urandom_range(1, CELL_W * 2) : $urandom_range(GRID_W * CELL_W - 2, GRID_W * CELL_W + 8),
            $urandom_range(2, 6), f[0]);
      repeat (3) step(1'b0, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
